// File: rtl/y86_imem_encoder.sv
// Serialises one decoded Y86 instruction into 1..10 imem byte writes at a running address.
// Latency: byte k of an instruction accepted in cycle T is written in cycle T+1+k; done in T+N.
// Backpressure: in_ready is low for the whole emission and while set_base or reset is asserted.
module y86_imem_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic [ADDR_W-1:0] valP,
  output logic              err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [3:0]        icode_q, ifun_q, ra_q, rb_q;
  logic [63:0]       valc_q;
  logic [3:0]        len_q;
  logic [3:0]        idx_q;
  logic [ADDR_W-1:0] valp_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [7:0]        last_wdata_q;
  logic              err_q;

  logic              accept;
  logic              icode_bad;
  logic              last_byte;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        cur_byte;
  logic [2:0]        valc_sel;
  logic [63:0]       valc_shift;

  // Encoded length of an instruction; only meaningful for icode 0..B.
  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  assign in_ready  = (state_q == IDLE) && !set_base && !reset;
  assign accept    = in_valid && in_ready;
  assign icode_bad = (icode > 4'hB);
  assign last_byte = (idx_q == (len_q - 4'd1));
  assign cur_addr  = valp_q + ADDR_W'(idx_q);
  assign valP      = valp_q;
  assign err       = err_q;

  // Byte selection: b0 is the opcode, 9-byte forms have no register byte before valC.
  always_comb begin
    cur_byte   = {icode_q, ifun_q};
    valc_sel   = 3'd0;
    valc_shift = 64'd0;
    if (idx_q != 4'd0) begin
      if (len_q == 4'd9) begin
        valc_sel = 3'(idx_q - 4'd1);
      end else begin
        valc_sel = 3'(idx_q - 4'd2);
      end
      valc_shift = valc_q >> {valc_sel, 3'b000};
      if (len_q != 4'd9 && idx_q == 4'd1) begin
        cur_byte = {ra_q, rb_q};
      end else begin
        cur_byte = valc_shift[7:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an accepted valid icode starts emission; the last byte returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !icode_bad) state_d = EMIT;
      EMIT:    if (last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: write port is live only in EMIT, otherwise it holds the last byte written.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    done      = 1'b0;
    if (state_q == EMIT) begin
      mem_we    = 1'b1;
      mem_addr  = cur_addr;
      mem_wdata = cur_byte;
      done      = last_byte;
    end
  end

  // Datapath: field latch, byte index, running address and held write-port values.
  always_ff @(posedge clk) begin
    if (reset) begin
      icode_q      <= 4'h0;
      ifun_q       <= 4'h0;
      ra_q         <= 4'h0;
      rb_q         <= 4'h0;
      valc_q       <= 64'd0;
      len_q        <= 4'd0;
      idx_q        <= 4'd0;
      valp_q       <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      err_q <= accept && icode_bad;
      if (state_q == IDLE) begin
        if (set_base) begin
          valp_q <= base_addr;
        end else if (accept && !icode_bad) begin
          icode_q <= icode;
          ifun_q  <= ifun;
          ra_q    <= rA;
          rb_q    <= rB;
          valc_q  <= valC;
          len_q   <= instr_len(icode);
          idx_q   <= 4'd0;
        end
      end else begin
        last_addr_q  <= cur_addr;
        last_wdata_q <= cur_byte;
        idx_q        <= idx_q + 4'd1;
        if (last_byte) begin
          valp_q <= valp_q + ADDR_W'(len_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Bench for y86_imem_encoder: directed instruction scenarios plus randomized traffic.
// Expected byte streams come from a field-list model of the Y86 encoding.
// A negedge monitor records every write and err pulse for comparison.
module tb_y86_imem_encoder;
  localparam int AW  = 10;
  localparam int MSZ = 1024;

  logic          clk = 1'b0;
  logic          reset, set_base, in_valid, in_ready;
  logic [AW-1:0] base_addr, mem_addr, valP;
  logic [3:0]    icode, ifun, rA, rB;
  logic [63:0]   valC;
  logic          mem_we, done, err;
  logic [7:0]    mem_wdata;

  y86_imem_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .set_base(set_base), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done), .valP(valP), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int   cyc;
    int   addr;
    int   data;
    logic dn;
  } wr_t;

  wr_t obs_q[$], exp_q[$];
  int  obs_err_q[$], exp_err_q[$];
  int  checks = 0, errors = 0;
  int  rdy_in_emit = 0, done_no_we = 0;
  int  m_valp = 0;

  // Monitor: record writes and err pulses in the middle of each cycle.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1) begin
      w.cyc  = cyc;
      w.addr = int'(mem_addr);
      w.data = int'(mem_wdata);
      w.dn   = done;
      obs_q.push_back(w);
      if (in_ready !== 1'b0) rdy_in_emit++;
    end else if (done === 1'b1) begin
      done_no_we++;
    end
    if (err === 1'b1) obs_err_q.push_back(cyc);
  end

  // Reference: an instruction is its opcode byte, an optional register byte, an optional 8-byte valC.
  task automatic model_instr(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vc, input int acc);
    int  bytes[$];
    wr_t w;
    if (ic > 4'hB) begin
      exp_err_q.push_back(acc + 1);
      return;
    end
    bytes.push_back(int'({ic, ifn}));
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) bytes.push_back(int'({ra, rb}));
    if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
      for (int i = 0; i < 8; i++) bytes.push_back(int'(vc[8*i +: 8]));
    for (int k = 0; k < bytes.size(); k++) begin
      w.cyc  = acc + 1 + k;
      w.addr = (m_valp + k) % MSZ;
      w.data = bytes[k];
      w.dn   = (k == bytes.size() - 1);
      exp_q.push_back(w);
    end
    m_valp = (m_valp + bytes.size()) % MSZ;
  endtask

  task automatic clear_logs();
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; set_base = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_valp = 0;
  endtask

  task automatic load_base(input int b);
    @(negedge clk);
    set_base = 1'b1; base_addr = AW'(b);
    @(posedge clk); #1;
    set_base = 1'b0;
    m_valp = b % MSZ;
  endtask

  // Present one instruction and hold it until accepted; acc is the accept cycle.
  task automatic issue(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input bit keep, output int acc);
    int guard = 0;
    @(negedge clk);
    icode = ic; ifun = ifn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      acc = -100;
      return;
    end
    acc = cyc;
    model_instr(ic, ifn, ra, rb, vc, acc);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
    {icode, ifun, rA, rB} = 16'($urandom);
    valC = {$urandom, $urandom};
  endtask

  // Wait for in_ready; rc is the first cycle it is seen high.
  task automatic wait_idle(output int rc);
    int guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    rc = cyc;
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL idle_timeout in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we_in_reset got %b want 0", mem_we); end
    reset = 1'b0; #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d want 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %02h want 00", mem_wdata); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    checks++; if (valP !== '0) begin errors++; $display("FAIL rst_valP got %0d want 0", valP); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_halt();
    int acc, rc;
    do_reset();
    clear_logs();
    issue(4'h0, 4'h0, 4'(($urandom)), 4'($urandom), {$urandom, $urandom}, 1'b0, acc);
    wait_idle(rc);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL halt_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL halt_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].dn); end
    end
    checks++; if (valP !== AW'(1)) begin errors++; $display("FAIL halt_valP got %0d want 1", valP); end
    checks++; if (rc != acc + 2) begin errors++; $display("FAIL halt_ready_cycle got %0d want %0d", rc, acc + 2); end
  endtask

  task automatic test_irmovq();
    int acc, rc;
    int want[10] = '{8'h30, 8'hF2, 8'hCD, 8'hAB, 0, 0, 0, 0, 0, 0};
    load_base(6);
    clear_logs();
    issue(4'h3, 4'h0, 4'hF, 4'h2, 64'hABCD, 1'b0, acc);
    wait_idle(rc);
    checks++; if (obs_q.size() != 10) begin errors++; $display("FAIL irmovq_nwrites got %0d want 10", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data != want[i] || obs_q[i].addr != 6 + i) begin errors++; $display("FAIL irmovq_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, 6 + i, want[i], exp_q[i].dn); end
    end
    checks++; if (valP !== AW'(16)) begin errors++; $display("FAIL irmovq_valP got %0d want 16", valP); end
    checks++; if (rc != acc + 11) begin errors++; $display("FAIL irmovq_ready_cycle got %0d want %0d", rc, acc + 11); end
  endtask

  task automatic test_jle();
    int acc, rc;
    int want[9] = '{8'h71, 8'h00, 8'h04, 0, 0, 0, 0, 0, 0};
    load_base(41);
    clear_logs();
    issue(4'h7, 4'h1, 4'($urandom), 4'($urandom), 64'h400, 1'b0, acc);
    wait_idle(rc);
    checks++; if (obs_q.size() != 9) begin errors++; $display("FAIL jle_nwrites got %0d want 9", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data != want[i] || obs_q[i].addr != 41 + i) begin errors++; $display("FAIL jle_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, 41 + i, want[i], exp_q[i].dn); end
    end
    checks++; if (valP !== AW'(50)) begin errors++; $display("FAIL jle_valP got %0d want 50", valP); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, rc;
    int want[4] = '{8'h10, 8'h60, 8'h02, 8'h90};
    do_reset();
    clear_logs();
    rdy_in_emit = 0;
    issue(4'h1, 4'h0, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b1, a0);
    issue(4'h6, 4'h0, 4'h0, 4'h2, {$urandom, $urandom}, 1'b1, a1);
    issue(4'h9, 4'h0, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, a2);
    wait_idle(rc);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL b2b_nwrites got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].data != want[i]) begin errors++; $display("FAIL b2b_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, exp_q[i].addr, want[i], exp_q[i].dn); end
    end
    checks++; if (a1 != a0 + 2 || a2 != a1 + 3) begin errors++; $display("FAIL b2b_accept_spacing got %0d,%0d want 2,3", a1 - a0, a2 - a1); end
    checks++; if (rdy_in_emit != 0) begin errors++; $display("FAIL b2b_ready_in_emit got %0d want 0", rdy_in_emit); end
    checks++; if (valP !== AW'(4)) begin errors++; $display("FAIL b2b_valP got %0d want 4", valP); end
  endtask

  task automatic test_bad_icode();
    int acc, rc;
    logic [AW-1:0] vp;
    clear_logs();
    vp = valP;
    issue(4'hC, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, acc);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bad_ready_next got %b want 1", in_ready); end
    issue(4'($urandom_range(13, 15)), 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, acc);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bad_nwrites got %0d want 0", obs_q.size()); end
    checks++; if (obs_err_q != exp_err_q) begin errors++; $display("FAIL bad_err_pulses got %p want %p", obs_err_q, exp_err_q); end
    checks++; if (valP !== vp) begin errors++; $display("FAIL bad_valP got %0d want %0d", valP, vp); end
  endtask

  task automatic test_set_base_priority();
    int c0, acc, rc;
    clear_logs();
    wait_idle(rc);
    set_base = 1'b1; base_addr = AW'(100); in_valid = 1'b1; icode = 4'h1; ifun = 4'h0;
    c0 = cyc;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL prio_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    set_base = 1'b0;
    m_valp = 100;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_after got %b want 1", in_ready); end
    model_instr(4'h1, 4'h0, rA, rB, valC, c0 + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    issue(4'h5, 4'h0, 4'h3, 4'h4, {$urandom, $urandom}, 1'b0, acc);
    @(negedge clk);
    set_base = 1'b1; base_addr = AW'(500);
    repeat (2) @(negedge clk);
    set_base = 1'b0;
    wait_idle(rc);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL prio_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL prio_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].dn); end
    end
    checks++; if (valP !== AW'(111)) begin errors++; $display("FAIL prio_valP got %0d want 111", valP); end
  endtask

  task automatic test_wrap_and_abort();
    int acc, rc, guard;
    load_base(1020);
    clear_logs();
    issue(4'h4, 4'h0, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, acc);
    wait_idle(rc);
    checks++; if (obs_q.size() != 10) begin errors++; $display("FAIL wrap_nwrites got %0d want 10", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].addr != (1020 + i) % MSZ) begin errors++; $display("FAIL wrap_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, (1020 + i) % MSZ, exp_q[i].data, exp_q[i].dn); end
    end
    checks++; if (valP !== AW'(6)) begin errors++; $display("FAIL wrap_valP got %0d want 6", valP); end
    load_base(1020);
    clear_logs();
    issue(4'h4, 4'h0, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, acc);
    guard = 0;
    @(negedge clk);
    while (cyc < acc + 4 && guard < 20) begin @(negedge clk); guard++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we got %b want 0", mem_we); end
    checks++; if (valP !== '0) begin errors++; $display("FAIL abort_valP got %0d want 0", valP); end
    reset = 1'b0;
    m_valp = 0;
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL abort_nwrites got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].dn); end
    end
  endtask

  task automatic test_random();
    int acc, rc;
    clear_logs();
    done_no_we = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        wait_idle(rc);
        load_base(int'($urandom_range(0, MSZ - 1)));
      end
      issue(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
            {$urandom, $urandom}, 1'b0, acc);
    end
    wait_idle(rc);
    repeat (2) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_nwrites got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_write%0d got c%0d a%0d d%02h done%0b want c%0d a%0d d%02h done%0b", i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, obs_q[i].dn, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].dn); end
    end
    checks++; if (obs_err_q != exp_err_q) begin errors++; $display("FAIL rand_err_pulses got %0d pulses want %0d", obs_err_q.size(), exp_err_q.size()); end
    checks++; if (int'(valP) != m_valp) begin errors++; $display("FAIL rand_valP got %0d want %0d", valP, m_valp); end
    checks++; if (done_no_we != 0) begin errors++; $display("FAIL rand_done_without_we got %0d want 0", done_no_we); end
  endtask

  initial begin
    reset = 1'b1; set_base = 1'b0; in_valid = 1'b0; base_addr = '0;
    icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = 64'd0;
    test_reset();
    test_halt();
    test_irmovq();
    test_jle();
    test_back_to_back();
    test_bad_icode();
    test_set_base_priority();
    test_wrap_and_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
